// File: rtl/nibbler_pkg.sv
// Shared types and default parameters for the nibbler core:
// opcode set, control states and the reset-time configuration constants.
package nibbler_pkg;

  localparam int DEF_DATA_W      = 4;
  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_STACK_DEPTH = 4;
  localparam int OPC_W           = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_CMPI = 4'h3,
    OP_NORI = 4'h4,
    OP_IN   = 4'h5,
    OP_OUT  = 4'h6,
    OP_JMP  = 4'h7,
    OP_JC   = 4'h8,
    OP_JZ   = 4'h9,
    OP_JNZ  = 4'hA,
    OP_CALL = 4'hB,
    OP_RET  = 4'hC,
    OP_ANDI = 4'hD,
    OP_XORI = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/nibbler_stack.sv
// Return-address LIFO: push writes at sp and increments, pop reads sp-1 and
// decrements. Callers must not push when full or pop when empty.
module nibbler_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]  sp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = IDX_W'(sp);
  assign rd_idx = IDX_W'(sp - SP_W'(1));
  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);
  assign dout   = mem[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // NOTE: entries are not reset; sp alone defines which entries are live,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/nibbler_core.sv
// Fetch/execute core: FETCH waits on prog_valid and latches IR, EXEC applies
// one instruction to A/flags/PC/stack, HALT is left only through reset.
module nibbler_core
  import nibbler_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDR_W-1:0]       prog_addr,
  output logic                    prog_req,
  input  logic                    prog_valid,
  input  logic [OPC_W+ADDR_W-1:0] prog_data,
  input  logic [DATA_W-1:0]       in_port,
  output logic [DATA_W-1:0]       out_port,
  output logic                    out_stb,
  output logic [DATA_W-1:0]       acc,
  output logic                    flag_c,
  output logic                    flag_z,
  output logic                    halted,
  output logic                    fault
);

  state_e                    state, state_n;
  logic [ADDR_W-1:0]         pc, pc_n, pc_inc;
  logic [OPC_W+ADDR_W-1:0]   ir;
  opcode_e                   op;
  logic [ADDR_W-1:0]         imm;
  logic [DATA_W-1:0]         imm_d;
  logic [DATA_W:0]           sum;
  logic [DATA_W-1:0]         acc_n, out_port_n;
  logic                      c_n, z_n, stb_n, fault_n;
  logic                      push, pop, stk_full, stk_empty;
  logic [ADDR_W-1:0]         ret_addr;

  assign op     = opcode_e'(ir[OPC_W+ADDR_W-1:ADDR_W]);
  assign imm    = ir[ADDR_W-1:0];
  assign imm_d  = imm[DATA_W-1:0];
  assign pc_inc = pc + ADDR_W'(1);
  assign sum    = {1'b0, acc} + {1'b0, imm_d};

  assign prog_addr = pc;
  assign prog_req  = (state == ST_FETCH);
  assign halted    = (state == ST_HALT);

  nibbler_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ret_addr),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // NOTE: every output of this block is given a default first, so no path
  // through the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    acc_n      = acc;
    c_n        = flag_c;
    z_n        = flag_z;
    out_port_n = out_port;
    stb_n      = 1'b0;
    fault_n    = fault;
    push       = 1'b0;
    pop        = 1'b0;

    case (state)
      ST_FETCH: if (prog_valid) state_n = ST_EXEC;
      ST_EXEC: begin
        state_n = ST_FETCH;
        pc_n    = pc_inc;
        case (op)
          OP_NOP: ;
          OP_LDI: begin acc_n = imm_d; z_n = (imm_d == '0); end
          OP_ADDI: begin
            acc_n = sum[DATA_W-1:0];
            c_n   = sum[DATA_W];
            z_n   = (sum[DATA_W-1:0] == '0);
          end
          OP_CMPI: begin c_n = (acc >= imm_d); z_n = (acc == imm_d); end
          OP_NORI: begin acc_n = ~(acc | imm_d); z_n = ((acc | imm_d) == '1); end
          OP_IN:   begin acc_n = in_port; z_n = (in_port == '0); end
          OP_OUT:  begin out_port_n = acc; stb_n = 1'b1; end
          OP_JMP:  pc_n = imm;
          OP_JC:   if (flag_c) pc_n = imm;
          OP_JZ:   if (flag_z) pc_n = imm;
          OP_JNZ:  if (!flag_z) pc_n = imm;
          OP_CALL: begin
            if (stk_full) begin
              pc_n    = pc;
              fault_n = 1'b1;
              state_n = ST_HALT;
            end else begin
              push = 1'b1;
              pc_n = imm;
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              pc_n    = pc;
              fault_n = 1'b1;
              state_n = ST_HALT;
            end else begin
              pop  = 1'b1;
              pc_n = ret_addr;
            end
          end
          OP_ANDI: begin acc_n = acc & imm_d; z_n = ((acc & imm_d) == '0); end
          OP_XORI: begin acc_n = acc ^ imm_d; z_n = ((acc ^ imm_d) == '0); end
          OP_HALT: begin pc_n = pc; state_n = ST_HALT; end
        endcase
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_FETCH;
      pc       <= '0;
      ir       <= '0;
      acc      <= '0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      out_port <= '0;
      out_stb  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      acc      <= acc_n;
      flag_c   <= c_n;
      flag_z   <= z_n;
      out_port <= out_port_n;
      out_stb  <= stb_n;
      fault    <= fault_n;
      if (state == ST_FETCH && prog_valid) ir <= prog_data;
    end
  end

endmodule

// File: tb/tb_nibbler_core.sv
// Self-checking bench: a wait-stated ROM responder drives the core, and an
// instruction-level model of the ISA predicts the final architectural state.
module tb_nibbler_core;

  localparam int DW = 4;
  localparam int AW = 12;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] prog_addr;
  logic          prog_req;
  logic          prog_valid;
  logic [15:0]   prog_data;
  logic [DW-1:0] in_port;
  logic [DW-1:0] out_port;
  logic          out_stb;
  logic [DW-1:0] acc;
  logic          flag_c, flag_z, halted, fault;

  nibbler_core #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_addr  (prog_addr),
    .prog_req   (prog_req),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .in_port    (in_port),
    .out_port   (out_port),
    .out_stb    (out_stb),
    .acc        (acc),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] rom [4096];

  function automatic logic [15:0] ins(input int op, input int imm);
    return {op[3:0], imm[11:0]};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = ins(15, 0);
  endtask

  // ---------------- instruction-level reference model ----------------
  int m_pc, m_a, m_c, m_z, m_fault, m_steps;
  int m_outs[$];
  int m_stk[$];

  task automatic model_run(input int in_val, output bit done);
    int op, imm, i4, nxt, s;
    m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_fault = 0; m_steps = 0;
    m_outs.delete(); m_stk.delete();
    done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      op  = int'(rom[m_pc][15:12]);
      imm = int'(rom[m_pc][11:0]);
      i4  = imm % 16;
      nxt = (m_pc + 1) % 4096;
      m_steps++;
      case (op)
        1:  begin m_a = i4; m_z = (m_a == 0); end
        2:  begin s = m_a + i4; m_c = (s > 15); m_a = s % 16; m_z = (m_a == 0); end
        3:  begin m_z = (m_a == i4); m_c = (m_a >= i4); end
        4:  begin m_a = 15 - (m_a | i4); m_z = (m_a == 0); end
        5:  begin m_a = in_val; m_z = (m_a == 0); end
        6:  m_outs.push_back(m_a);
        13: begin m_a = m_a & i4; m_z = (m_a == 0); end
        14: begin m_a = m_a ^ i4; m_z = (m_a == 0); end
        default: ;
      endcase
      if (op == 15) begin done = 1'b1; return; end
      if (op == 11) begin
        if (m_stk.size() == SD) begin m_fault = 1; done = 1'b1; return; end
        m_stk.push_back(nxt);
      end
      if (op == 12) begin
        if (m_stk.size() == 0) begin m_fault = 1; done = 1'b1; return; end
        nxt = m_stk.pop_back();
      end
      if (op == 7 || op == 11 || (op == 8 && m_c == 1) || (op == 9 && m_z == 1) ||
          (op == 10 && m_z == 0))
        nxt = imm;
      m_pc = nxt;
    end
  endtask

  // ---------------- DUT driver ----------------
  int waits_total, addr_bad, stb_cnt;
  int out_q[$];

  // wmode >= 0: fixed wait states per fetch; wmode < 0: random 0..3.
  task automatic run_dut(input int wmode, input int budget, output int cycles);
    bit busy;
    int w;
    logic [AW-1:0] a0;
    busy = 1'b0; w = 0; a0 = '0; cycles = 0;
    while (!halted && cycles < budget) begin
      if (prog_req) begin
        if (!busy) begin
          busy = 1'b1;
          a0   = prog_addr;
          w    = (wmode < 0) ? int'($urandom_range(0, 3)) : wmode;
          waits_total += w;
        end else if (prog_addr !== a0) begin
          addr_bad++;
        end
        if (w == 0) begin
          prog_valid = 1'b1;
          prog_data  = rom[prog_addr];
          busy       = 1'b0;
        end else begin
          prog_valid = 1'b0;
          prog_data  = 16'($urandom);
          w--;
        end
      end else begin
        prog_valid = 1'($urandom);
        prog_data  = 16'($urandom);
      end
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (out_stb) begin
        stb_cnt++;
        out_q.push_back(int'(out_port));
      end
    end
    prog_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    prog_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".req"},   32'(prog_req),  32'd1);
    check({tag, ".addr"},  32'(prog_addr), 32'd0);
    check({tag, ".acc"},   32'(acc),       32'd0);
    check({tag, ".c"},     32'(flag_c),    32'd0);
    check({tag, ".z"},     32'(flag_z),    32'd0);
    check({tag, ".out"},   32'(out_port),  32'd0);
    check({tag, ".stb"},   32'(out_stb),   32'd0);
    check({tag, ".halt"},  32'(halted),    32'd0);
    check({tag, ".fault"}, 32'(fault),     32'd0);
  endtask

  // Assumes reset was just released at a falling edge.
  task automatic run_and_compare(input string tag, input int wmode, output int cycles);
    bit done;
    int last;
    waits_total = 0; addr_bad = 0; stb_cnt = 0; out_q.delete();
    model_run(int'(in_port), done);
    run_dut(wmode, 2000, cycles);
    check({tag, ".halted"}, 32'(halted),    32'd1);
    check({tag, ".req"},    32'(prog_req),  32'd0);
    check({tag, ".acc"},    32'(acc),       32'(m_a));
    check({tag, ".c"},      32'(flag_c),    32'(m_c));
    check({tag, ".z"},      32'(flag_z),    32'(m_z));
    check({tag, ".pc"},     32'(prog_addr), 32'(m_pc));
    check({tag, ".fault"},  32'(fault),     32'(m_fault));
    check({tag, ".sp"},     32'(dut.u_stack.sp), 32'(m_stk.size()));
    check({tag, ".stbs"},   32'(stb_cnt),   32'(m_outs.size()));
    for (int i = 0; i < m_outs.size() && i < out_q.size(); i++)
      check($sformatf("%s.outv%0d", tag, i), 32'(out_q[i]), 32'(m_outs[i]));
    last = (m_outs.size() > 0) ? m_outs[m_outs.size() - 1] : 0;
    check({tag, ".out"},    32'(out_port),  32'(last));
    check({tag, ".cycles"}, 32'(cycles),    32'(2 * m_steps + waits_total));
    check({tag, ".addrstable"}, 32'(addr_bad), 32'd0);
  endtask

  task automatic prog_wrap(input logic [15:0] at_top);
    clear_rom();
    rom[0]      = ins(9, 'h300);
    rom[1]      = ins(1, 0);
    rom[2]      = ins(7, 'hFFF);
    rom['hFFF]  = at_top;
    rom['h200]  = ins(12, 0);
    rom['h300]  = ins(15, 0);
  endtask

  initial begin
    int cyc, op, imm;
    bit done;

    reset = 1'b1; prog_valid = 1'b0; prog_data = '0; in_port = 4'h9;
    #3;
    check_reset_vals("por");
    clear_rom();
    do_reset();
    check_reset_vals("rel");

    // Add with carry, zero and three wait states.
    rom[0] = ins(1, 5); rom[1] = ins(2, 12); rom[2] = ins(15, 0);
    do_reset();
    run_and_compare("add0", 0, cyc);
    check("add0.lit", {31'd0, acc == 4'd1 && flag_c && !flag_z}, 32'd1);
    check("add0.ncyc", 32'(cyc), 32'd6);
    do_reset();
    run_and_compare("add3", 3, cyc);
    check("add3.ncyc", 32'(cyc), 32'd15);

    // Compare, taken JZ, OUT.
    clear_rom();
    rom[0] = ins(1, 3); rom[1] = ins(3, 3); rom[2] = ins(9, 'h100);
    rom['h100] = ins(6, 0); rom['h101] = ins(15, 0);
    do_reset();
    run_and_compare("cmpout", -1, cyc);
    check("cmpout.lit", {31'd0, out_port == 4'd3 && flag_c && flag_z}, 32'd1);

    // Five nested CALLs overflow a four-entry stack.
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i * 16] = ins(11, (i + 1) * 16);
    do_reset();
    run_and_compare("ovf", -1, cyc);
    check("ovf.pc_lit", 32'(prog_addr), 32'h40);

    // Reset while halted clears everything and restarts from 0.
    #2 reset = 1'b1;
    #1 check_reset_vals("rsthalt");
    @(negedge clk) reset = 1'b0;
    run_and_compare("ovf2", 0, cyc);

    // Four CALL/RET pairs unwind back to address 1.
    clear_rom();
    rom[0] = ins(11, 'h10); rom[1] = ins(15, 0);
    for (int i = 1; i < 4; i++) begin
      rom[i * 16]     = ins(11, (i + 1) * 16);
      rom[i * 16 + 1] = ins(12, 0);
    end
    rom['h40] = ins(12, 0);
    do_reset();
    run_and_compare("nest4", -1, cyc);
    check("nest4.pc_lit", 32'(prog_addr), 32'h1);

    // RET on an empty stack.
    clear_rom();
    rom[0] = ins(1, 7); rom[1] = ins(12, 0);
    do_reset();
    run_and_compare("underflow", 1, cyc);

    // PC wrap past 0xFFF via NOP, and CALL at the last address pushing 0.
    prog_wrap(ins(0, 0));
    do_reset();
    run_and_compare("wrapnop", 0, cyc);
    prog_wrap(ins(11, 'h200));
    do_reset();
    run_and_compare("wrapcall", 2, cyc);

    // Reset during a wait-stated fetch abandons it.
    clear_rom();
    rom[0] = ins(1, 5); rom[1] = ins(2, 12); rom[2] = ins(15, 0);
    do_reset();
    waits_total = 0; addr_bad = 0; stb_cnt = 0;
    run_dut(3, 6, cyc);
    #2 reset = 1'b1;
    #1 check_reset_vals("rstfetch");
    @(negedge clk) reset = 1'b0;
    check("rstfetch.rel_req",  32'(prog_req),  32'd1);
    check("rstfetch.rel_addr", 32'(prog_addr), 32'd0);
    run_and_compare("rstfetch.rerun", 3, cyc);

    // Random programs confined to 0..31 with random wait states.
    for (int t = 0; t < 25; t++) begin
      done = 1'b0;
      while (!done) begin
        clear_rom();
        for (int i = 0; i < 32; i++) begin
          op = int'($urandom_range(0, 15));
          if (op == 15 && $urandom_range(0, 3) != 0) op = int'($urandom_range(0, 14));
          imm = (op >= 7 && op <= 11) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4095));
          rom[i] = ins(op, imm);
        end
        in_port = 4'($urandom);
        model_run(int'(in_port), done);
      end
      do_reset();
      run_and_compare($sformatf("rnd%0d", t), -1, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibbler_core.md
# nibbler_core

Parametrised successor to the breadboard Nibbler datapath: a self-contained fetch/execute core with an accumulator, carry/zero flags, a program counter, a call/return stack and a wait-state program-memory handshake. It replaces the fixed 4-bit, fixed-phase microcoded board with configurable data/address width, variable-latency instruction fetch, subroutine support and a fault/halt mechanism. It sits between an external program ROM (any latency) and a simple I/O port pair.

## Interface

- DATA_W, 4: accumulator, ALU and I/O width; must be ≤ ADDR_W.
- ADDR_W, 12: program address width and immediate field width.
- STACK_DEPTH, 4: return-address stack entries, ≥ 1.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_addr  out  ADDR_W  fetch address, equals PC.
- prog_req  out  1  fetch request, high only in FETCH.
- prog_valid  in  1  prog_data valid this cycle; ignored outside FETCH.
- prog_data  in  4+ADDR_W  instruction word {opcode[3:0], imm[ADDR_W-1:0]}.
- in_port  in  DATA_W  input sampled by IN.
- out_port  out  DATA_W  registered output written by OUT.
- out_stb  out  1  one-cycle pulse in the cycle after OUT executes.
- acc  out  DATA_W  accumulator value.
- flag_c, flag_z  out  1 each  carry and zero flags.
- halted  out  1  core is in HALT.
- fault  out  1  sticky stack-fault indicator.

## Operation

- States: FETCH, EXEC, HALT. FETCH → EXEC when prog_valid=1 (IR latched). EXEC → FETCH, or → HALT on HALT opcode or stack fault. HALT is exited only by reset.
- ALU immediate = imm[DATA_W-1:0]; jump/call target = imm (full ADDR_W).
- Opcodes: 0 NOP; 1 LDI A=imm; 2 ADDI A=A+imm, C=carry-out; 3 CMPI A unchanged, Z=(A==imm), C=(A≥imm) unsigned; 4 NORI A=~(A|imm); 5 IN A=in_port; 6 OUT out_port=A; 7 JMP; 8 JC (if C); 9 JZ (if Z); A JNZ (if !Z); B CALL; C RET; D ANDI; E XORI; F HALT.
- Flags: ADDI and CMPI update C and Z; LDI, NORI, IN, ANDI, XORI update Z=(result==0), C held; all others hold both.
- PC: non-taken/non-jump → PC+1 modulo 2^ADDR_W; taken jump/CALL → imm; RET → popped address.
- CALL: push PC+1 (wrapped; CALL at last address pushes 0). If stack full (sp==STACK_DEPTH): no push, PC held, fault=1, → HALT.
- RET: if sp==0: PC held, fault=1, → HALT.
- HALT opcode: PC held, fault unchanged.

## Timing

- Reset values: state FETCH, PC=0, A=0, C=Z=0, sp=0, out_port=0, out_stb=0, halted=0, fault=0, IR=0. Reset mid-fetch abandons the fetch; prog_req stays high with prog_addr=0 after release.
- prog_req, prog_addr combinational from state/PC. Fetch latency = 1 + wait cycles; a request is held with stable address until prog_valid.
- prog_valid=1 in the first FETCH cycle → minimum 2 cycles per instruction.
- EXEC results (A, flags, PC, sp, out_port) visible the cycle after EXEC; out_stb high that same cycle for exactly one cycle.
- halted asserts the cycle after the EXEC that entered HALT; prog_req=0 while halted.
- A CALL then immediate RET restores PC to the CALL address+1 with sp back to its prior value.

## Structure

- Package nibbler_pkg: opcode enum (4-bit), state enum, default parameter constants.
- Sub-module nibbler_stack: parametrised LIFO (width ADDR_W, depth STACK_DEPTH) with push/pop, full/empty, async reset clearing sp.
- Core holds FSM, PC, IR, accumulator/flag registers and the ALU as combinational logic.

## Test plan

- Reset then program LDI 5; ADDI 12; HALT (DATA_W=4), zero wait states → A=1, C=1, Z=0, halted after 6 cycles, prog_req low.
- Same program with prog_valid delayed 3 cycles per fetch → identical results, prog_addr stable while waiting, 15 cycles to halted.
- LDI 3; CMPI 3; JZ 0x100; at 0x100 OUT; HALT → out_port=3, single out_stb pulse, C=1, Z=1.
- Nested CALLs five deep with STACK_DEPTH=4 → fault=1, halted=1, PC equals fifth CALL address; four CALL/RET pairs return correctly with sp=0.
- RET with empty stack → fault=1, halted; JMP to 0xFFF then NOP → PC wraps to 0x000.
- Assert reset during a wait-stated fetch and during HALT → all outputs at reset values immediately, execution restarts from address 0.
